// File: rtl/ddr_pkg.sv
// Shared definitions for the note scheduler: lane indices, chart entry layout,
// end-of-chart marker and scheduler state encoding.
package ddr_pkg;

    localparam int LANES   = 4;
    localparam int ROW_W   = 8;
    localparam int MASK_W  = LANES;
    localparam int DELTA_W = 8;
    localparam int ENTRY_W = MASK_W + DELTA_W;
    localparam int PC_W    = $clog2(LANES + 1);

    localparam int LANE_L = 0;
    localparam int LANE_U = 1;
    localparam int LANE_D = 2;
    localparam int LANE_R = 3;

    // Chart entry is {mask, delta}
    localparam int DELTA_LSB = 0;
    localparam int DELTA_MSB = DELTA_W - 1;
    localparam int MASK_LSB  = DELTA_W;
    localparam int MASK_MSB  = ENTRY_W - 1;

    localparam logic [ENTRY_W-1:0] END_ROW = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_FIRE  = 3'd4,
        S_DONE  = 3'd5
    } sched_state_t;

    function automatic logic [PC_W-1:0] lane_popcount(input logic [LANES-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/note_scheduler.sv
// Walks a level chart row by row, counts frames between rows and pulses column starts.
// Optional DDR_DROP_COUNT_EN adds a saturating count of spawns lost to busy columns.
//
// state | meaning
// IDLE  | waiting for play
// FETCH | chart ROM read in flight
// LOAD  | latch {mask,delta}; END row finishes the chart
// WAIT  | count unpaused frames until cnt reaches delta
// FIRE  | start pulse high for this cycle; advance row
// DONE  | chart finished; play restarts
module note_scheduler
    import ddr_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame,
    input  logic [1:0]             i_level,
    input  logic                   i_play,
    input  logic                   i_stop,
    input  logic                   i_pause,
    input  logic [LANES-1:0]       i_col_busy,
    output logic [ROW_W+1:0]       o_rom_addr,
    input  logic [ENTRY_W-1:0]     i_rom_data,
    output logic [LANES-1:0]       o_start,
    output logic                   o_busy,
`ifdef DDR_DROP_COUNT_EN
    output logic [7:0]             o_dropped,
`endif
    output logic                   o_done
);

    sched_state_t       r_state;
    logic [ROW_W-1:0]   r_row;
    logic [DELTA_W-1:0] r_cnt;
    logic [1:0]         r_level;
    logic [MASK_W-1:0]  r_mask;
    logic [DELTA_W-1:0] r_delta;
    logic [ROW_W+1:0]   r_rom_addr;
    logic [LANES-1:0]   r_start;
    logic               r_busy;
    logic               r_done;
    logic [ROW_W-1:0]   w_row_next;

    assign w_row_next = r_row + ROW_W'(1);

`ifdef DDR_DROP_COUNT_EN
    logic [7:0] r_dropped;
    logic [8:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_dropped} + 9'(lane_popcount(r_mask & i_col_busy));
    assign o_dropped  = r_dropped;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dropped <= '0;
        end else if (!i_stop && i_play && (r_state == S_IDLE || r_state == S_DONE)) begin
            r_dropped <= '0;
        end else if (!i_stop && r_state == S_WAIT && r_cnt == r_delta) begin
            r_dropped <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_cnt      <= '0;
            r_level    <= '0;
            r_mask     <= '0;
            r_delta    <= '0;
            r_rom_addr <= '0;
            r_start    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start <= '0;
            if (i_stop) begin
                r_state    <= S_IDLE;
                r_row      <= '0;
                r_cnt      <= '0;
                r_rom_addr <= '0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (i_play) begin
                            r_level    <= i_level;
                            r_row      <= '0;
                            r_rom_addr <= {i_level, {ROW_W{1'b0}}};
                            r_state    <= S_FETCH;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                        end
                    end
                    S_FETCH: r_state <= S_LOAD;
                    S_LOAD: begin
                        r_mask  <= i_rom_data[MASK_MSB:MASK_LSB];
                        r_delta <= i_rom_data[DELTA_MSB:DELTA_LSB];
                        r_cnt   <= '0;
                        if (i_rom_data == END_ROW) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // start is registered on entry so it is high exactly during FIRE
                        if (r_cnt == r_delta) begin
                            r_state <= S_FIRE;
                            r_start <= r_mask & ~i_col_busy;
                        end else if (i_frame && !i_pause) begin
                            r_cnt <= r_cnt + DELTA_W'(1);
                        end
                    end
                    S_FIRE: begin
                        if (r_row == {ROW_W{1'b1}}) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row      <= w_row_next;
                            r_rom_addr <= {r_level, w_row_next};
                            r_state    <= S_FETCH;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_start    = r_start;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule
